// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word reads for the current PC and delivers
// the returned instruction, tagged with its PC, into a registered IF/ID stage.
module instr_fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              flush,
    input  logic              stall_in,
    output logic              busywait,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] pc_id,
    output logic              instr_valid
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] req_pc_p0;
    logic [DATA_W-1:0] hold_instr_p1;
    logic [ADDR_W-1:0] hold_pc_p1;

    logic              accept;
    logic              capture;
    logic              deliver;
    logic              from_hold;

    assign mem_addr = {pc_in[ADDR_W-1:2], 2'b00};

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        deliver    = 1'b0;
        from_hold  = 1'b0;
        case (state)
            S_REQ: begin
                mem_req = !flush;
                if (!flush && mem_ready) begin
                    accept     = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    // A killed fetch whose response has not arrived must be drained.
                    state_next = mem_rvalid ? S_REQ : S_DRAIN;
                end else if (mem_rvalid) begin
                    if (stall_in) begin
                        capture    = 1'b1;
                        state_next = S_HOLD;
                    end else begin
                        deliver    = 1'b1;
                        state_next = S_REQ;
                    end
                end
            end
            S_DRAIN: begin
                if (mem_rvalid) begin
                    state_next = S_REQ;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_next = S_REQ;
                end else if (!stall_in) begin
                    deliver    = 1'b1;
                    from_hold  = 1'b1;
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
        // The PC advances on delivery, and loads its branch target on flush.
        busywait = !(flush || deliver);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Request stage: PC of the outstanding fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_pc_p0 <= '0;
        end else if (accept) begin
            req_pc_p0 <= pc_in;
        end
    end

    // Hold buffer: response parked while IF/ID is stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_instr_p1 <= '0;
            hold_pc_p1    <= '0;
        end else if (capture) begin
            hold_instr_p1 <= mem_rdata;
            hold_pc_p1    <= req_pc_p0;
        end
    end

    // IF/ID output stage: flush beats delivery, delivery beats stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_out   <= NOP_INSTR;
            pc_id       <= '0;
            instr_valid <= 1'b0;
        end else if (flush) begin
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else if (deliver) begin
            instr_out   <= from_hold ? hold_instr_p1 : mem_rdata;
            pc_id       <= from_hold ? hold_pc_p1 : req_pc_p0;
            instr_valid <= 1'b1;
        end else if (!stall_in) begin
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table-driven fetches with a
// delivery scoreboard, plus hand-written reset and flush sequences.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        flush;
    logic        stall_in;
    logic        busywait;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_id;
    logic        instr_valid;

    instr_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .flush      (flush),
        .stall_in   (stall_in),
        .busywait   (busywait),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .instr_out  (instr_out),
        .pc_id      (pc_id),
        .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        int          ready_wait;
        int          rvalid_wait;
        int          stall_cycles;
        bit          hold_prev;
    } vec_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_valid = 1'b0;
        e_instr = NOP;
        e_pc    = '0;
        sb.delete();
    endtask

    task automatic check_outputs();
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, e_valid});
        chk("instr_out", instr_out, e_instr);
        chk("pc_id", pc_id, e_pc);
    endtask

    // One clock: check combinational outputs, step the model, check the stage.
    task automatic tick(input logic exp_req, input logic exp_bw, input logic deliver);
        exp_t e;
        logic [31:0] addr_exp;
        #1;
        chk("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
        chk("busywait", {31'b0, busywait}, {31'b0, exp_bw});
        if (exp_req) begin
            addr_exp = pc_in & 32'hFFFF_FFFC;
            chk("mem_addr", mem_addr, addr_exp);
        end
        @(posedge clk);
        if (flush) begin
            e_valid = 1'b0;
            e_instr = NOP;
        end else if (deliver) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got empty expected entry at %0t", $time);
            end else begin
                e = sb.pop_front();
                e_valid = 1'b1;
                e_instr = e.instr;
                e_pc    = e.pc;
            end
        end else if (!stall_in) begin
            e_valid = 1'b0;
            e_instr = NOP;
        end
        #1;
        check_outputs();
    endtask

    task automatic fetch(input vec_t v);
        exp_t e;
        pc_in    = v.pc;
        stall_in = v.hold_prev;
        for (int i = 0; i < v.ready_wait; i++) begin
            mem_ready = 1'b0;
            tick(1'b1, 1'b1, 1'b0);
        end
        mem_ready = 1'b1;
        tick(1'b1, 1'b1, 1'b0);
        mem_ready = 1'b0;
        for (int i = 0; i < v.rvalid_wait; i++) begin
            tick(1'b0, 1'b1, 1'b0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = v.rdata;
        stall_in   = (v.stall_cycles > 0);
        e.instr = v.rdata;
        e.pc    = v.pc;
        sb.push_back(e);
        if (v.stall_cycles == 0) begin
            tick(1'b0, 1'b0, 1'b1);
        end else begin
            tick(1'b0, 1'b1, 1'b0);
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hBAD0BAD0;
            for (int i = 1; i < v.stall_cycles; i++) begin
                tick(1'b0, 1'b1, 1'b0);
            end
            stall_in = 1'b0;
            tick(1'b0, 1'b0, 1'b1);
        end
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hBAD0BAD0;
        stall_in   = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h0000_0100, 32'h0050_0093, 0, 0, 0, 1'b0};
        vecs[1] = '{32'h0000_0104, 32'h0020_81B3, 3, 3, 0, 1'b0};
        vecs[2] = '{32'h0000_0108, 32'hDEAD_BEEF, 0, 0, 2, 1'b0};
        vecs[3] = '{32'h0000_010C, 32'hCAFE_F00D, 0, 1, 3, 1'b1};
        vecs[4] = '{32'h0000_010A, 32'h0000_A0B3, 1, 0, 1, 1'b0};
        vecs[5] = '{32'hFFFF_FFFC, 32'h1234_5678, 0, 2, 0, 1'b0};

        reset      = 1'b1;
        pc_in      = 32'h0000_0040;
        flush      = 1'b0;
        stall_in   = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;

        // Reset asserted asynchronously while waiting for a response
        mem_ready = 1'b1;
        tick(1'b1, 1'b1, 1'b0);
        mem_ready = 1'b0;
        tick(1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs();
        chk("mem_req_in_reset", {31'b0, mem_req}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pc_in = 32'h0000_0080;
        tick(1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            fetch(vecs[i]);
        end

        // Flush while waiting: response must be drained, never delivered
        pc_in     = 32'h0000_01F0;
        mem_ready = 1'b1;
        tick(1'b1, 1'b1, 1'b0);
        mem_ready = 1'b0;
        flush     = 1'b1;
        pc_in     = 32'h0000_0200;
        tick(1'b0, 1'b0, 1'b0);
        flush = 1'b0;
        tick(1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        flush      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        tick(1'b0, 1'b1, 1'b0);
        mem_rvalid = 1'b0;
        fetch('{32'h0000_0200, 32'h0040_0113, 0, 0, 0, 1'b0});

        // Flush coincident with a stalled response: flush wins
        pc_in     = 32'h0000_0300;
        mem_ready = 1'b1;
        tick(1'b1, 1'b1, 1'b0);
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h2222_2222;
        stall_in   = 1'b1;
        flush      = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        mem_rvalid = 1'b0;
        stall_in   = 1'b0;
        flush      = 1'b0;
        pc_in      = 32'h0000_0304;
        tick(1'b1, 1'b1, 1'b0);

        // Flush in REQ masks the request even with mem_ready high
        pc_in     = 32'h0000_0400;
        mem_ready = 1'b1;
        flush     = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        flush     = 1'b0;
        mem_ready = 1'b0;
        fetch('{32'h0000_0400, 32'h0010_0193, 0, 0, 0, 1'b0});

        // Flush while holding a stalled response drops the buffer
        pc_in     = 32'h0000_0500;
        mem_ready = 1'b1;
        tick(1'b1, 1'b1, 1'b0);
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h3333_3333;
        stall_in   = 1'b1;
        tick(1'b0, 1'b1, 1'b0);
        mem_rvalid = 1'b0;
        flush      = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        flush    = 1'b0;
        stall_in = 1'b0;
        fetch('{32'h0000_0504, 32'h0030_0213, 0, 1, 0, 1'b0});

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
